// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - cop0 exception-entry and ERET sequencer
module exception_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter logic [4:0]  REG_BADVADDR = 5'd8,
    parameter logic [4:0]  REG_STATUS   = 5'd12,
    parameter logic [4:0]  REG_CAUSE    = 5'd13,
    parameter logic [4:0]  REG_EPC      = 5'd14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_exc,
    input  logic [4:0]  mem_code,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_badvaddr,
    input  logic        ex_exc,
    input  logic [4:0]  ex_code,
    input  logic [31:0] ex_pc,
    input  logic        id_exc,
    input  logic [4:0]  id_code,
    input  logic [31:0] id_pc,
    input  logic        if_exc,
    input  logic [31:0] if_pc,
    input  logic        int_ext,
    input  logic        eret,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic        cop_we,
    output logic [4:0]  cop_wreg,
    output logic [31:0] cop_wdata,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_BADV,
        SAVE_CAUSE,
        SAVE_STATUS,
        ERET_STATUS,
        REDIRECT
    } state_t;

    state_t      state, state_n;

    logic [4:0]  lat_code;
    logic [31:0] lat_pc;
    logic [31:0] lat_badv;
    logic [31:0] lat_target;

    logic        sel_take;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc;
    logic [31:0] sel_badv;
    logic        sel_addr;
    logic        lat_addr;
    logic        int_ok;

    logic        cop_we_d;
    logic [4:0]  cop_wreg_d;
    logic [31:0] cop_wdata_d;
    logic        pc_redirect_d;
    logic [31:0] pc_target_d;
    logic        busy_d;

    // Age-priority pick among the stage requests; the interrupt only counts when enabled and not already in EXL
    always_comb begin
        int_ok   = int_ext & status_in[0] & ~status_in[1];
        sel_take = 1'b1;
        sel_code = 5'd0;
        sel_pc   = 32'd0;
        sel_badv = 32'd0;
        if (mem_exc) begin
            sel_code = mem_code;
            sel_pc   = mem_pc;
            sel_badv = mem_badvaddr;
        end else if (ex_exc) begin
            sel_code = ex_code;
            sel_pc   = ex_pc;
        end else if (id_exc) begin
            sel_code = id_code;
            sel_pc   = id_pc;
        end else if (if_exc) begin
            sel_code = 5'd4;
            sel_pc   = if_pc;
            sel_badv = if_pc;
        end else if (int_ok) begin
            sel_code = 5'd0;
            sel_pc   = mem_pc;
        end else begin
            sel_take = 1'b0;
        end
        sel_addr = (sel_code == 5'd4) || (sel_code == 5'd5);
        lat_addr = (lat_code == 5'd4) || (lat_code == 5'd5);
    end

    // Next state plus the write-port/redirect values that the output stage registers one cycle later
    always_comb begin
        state_n       = state;
        cop_we_d      = 1'b0;
        cop_wreg_d    = 5'd0;
        cop_wdata_d   = 32'd0;
        pc_redirect_d = 1'b0;
        pc_target_d   = 32'd0;
        busy_d        = (state != IDLE);
        case (state)
            IDLE: begin
                if (sel_take) begin
                    if (status_in[1])
                        state_n = sel_addr ? SAVE_BADV : SAVE_CAUSE;
                    else
                        state_n = SAVE_EPC;
                end else if (eret) begin
                    state_n = ERET_STATUS;
                end
            end
            SAVE_EPC: begin
                cop_we_d    = 1'b1;
                cop_wreg_d  = REG_EPC;
                cop_wdata_d = lat_pc;
                state_n     = lat_addr ? SAVE_BADV : SAVE_CAUSE;
            end
            SAVE_BADV: begin
                cop_we_d    = 1'b1;
                cop_wreg_d  = REG_BADVADDR;
                cop_wdata_d = lat_badv;
                state_n     = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                cop_we_d    = 1'b1;
                cop_wreg_d  = REG_CAUSE;
                cop_wdata_d = {25'd0, lat_code, 2'b00};
                state_n     = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                cop_we_d    = 1'b1;
                cop_wreg_d  = REG_STATUS;
                cop_wdata_d = (status_in | 32'h0000_0002) & ~32'h0000_0010;
                state_n     = REDIRECT;
            end
            ERET_STATUS: begin
                cop_we_d    = 1'b1;
                cop_wreg_d  = REG_STATUS;
                cop_wdata_d = status_in & ~32'h0000_0002;
                state_n     = REDIRECT;
            end
            REDIRECT: begin
                pc_redirect_d = 1'b1;
                pc_target_d   = lat_target;
                state_n       = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Capture the chosen request in IDLE and the return address on the way into REDIRECT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_code   <= 5'd0;
            lat_pc     <= 32'd0;
            lat_badv   <= 32'd0;
            lat_target <= 32'd0;
        end else begin
            if (state == IDLE && sel_take) begin
                lat_code <= sel_code;
                lat_pc   <= sel_pc;
                lat_badv <= sel_badv;
            end
            if (state == SAVE_STATUS)
                lat_target <= HANDLER_ADDR;
            else if (state == ERET_STATUS)
                lat_target <= epc_in;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cop_we      <= 1'b0;
            cop_wreg    <= 5'd0;
            cop_wdata   <= 32'd0;
            flush       <= 1'b0;
            stall       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= 32'd0;
            busy        <= 1'b0;
        end else begin
            cop_we      <= cop_we_d;
            cop_wreg    <= cop_wreg_d;
            cop_wdata   <= cop_wdata_d;
            flush       <= busy_d;
            stall       <= busy_d;
            pc_redirect <= pc_redirect_d;
            pc_target   <= pc_target_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - scoreboard bench for exception_sequencer
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_exc, ex_exc, id_exc, if_exc, int_ext, eret;
    logic [4:0]  mem_code, ex_code, id_code;
    logic [31:0] mem_pc, mem_badvaddr, ex_pc, id_pc, if_pc, status_in, epc_in;
    logic        cop_we, flush, stall, pc_redirect, busy;
    logic [4:0]  cop_wreg;
    logic [31:0] cop_wdata, pc_target;

    int vectors = 0;
    int miscompares = 0;
    logic [37:0] sb[$];

    localparam logic [31:0] HANDLER = 32'h8000_0180;

    exception_sequencer dut (
        .clk(clk), .reset(reset),
        .mem_exc(mem_exc), .mem_code(mem_code), .mem_pc(mem_pc), .mem_badvaddr(mem_badvaddr),
        .ex_exc(ex_exc), .ex_code(ex_code), .ex_pc(ex_pc),
        .id_exc(id_exc), .id_code(id_code), .id_pc(id_pc),
        .if_exc(if_exc), .if_pc(if_pc), .int_ext(int_ext), .eret(eret),
        .status_in(status_in), .epc_in(epc_in),
        .cop_we(cop_we), .cop_wreg(cop_wreg), .cop_wdata(cop_wdata),
        .flush(flush), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] wr(input logic [4:0] r, input logic [31:0] d);
        return {1'b0, r, d};
    endfunction

    function automatic logic [37:0] rd(input logic [31:0] t);
        return {1'b1, 5'd0, t};
    endfunction

    // Monitor: every write or redirect must match the head of the expected queue
    always @(negedge clk) begin
        logic [37:0] got;
        logic [37:0] exp;
        if (reset) begin
            if (cop_we || pc_redirect) begin
                got = pc_redirect ? {1'b1, 5'd0, pc_target} : {1'b0, cop_wreg, cop_wdata};
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output actual=%h expected=none", got);
                end else begin
                    exp = sb.pop_front();
                    chk("scoreboard", 64'(got), 64'(exp));
                end
            end
            if (!cop_we)
                chk("idle_write_port", 64'({cop_wreg, cop_wdata}), 64'd0);
        end
    end

    task automatic clear_reqs();
        mem_exc = 0; ex_exc = 0; id_exc = 0; if_exc = 0; int_ext = 0; eret = 0;
    endtask

    // Requests are set up by the caller before this; they are sampled at the next edge then dropped
    task automatic go(input string name, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        clear_reqs();
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (pc_redirect) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        repeat (2) @(negedge clk);
        #1;
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        clear_reqs();
        mem_code = 0; ex_code = 0; id_code = 0;
        mem_pc = 0; mem_badvaddr = 0; ex_pc = 0; id_pc = 0; if_pc = 0;
        status_in = 0; epc_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outputs", 64'({cop_we, flush, stall, pc_redirect, pc_target}), 64'd0);
        @(negedge clk) reset = 1;
        repeat (2) @(negedge clk);

        // Non-address EX exception
        status_in = 32'h0; ex_exc = 1; ex_code = 12; ex_pc = 32'h0040_0010;
        sb.push_back(wr(14, 32'h0040_0010));
        sb.push_back(wr(13, 32'h30));
        sb.push_back(wr(12, 32'h2));
        sb.push_back(rd(HANDLER));
        go("ex_ovf", 4);

        // MEM address error beats a simultaneous SYS in ID
        @(negedge clk);
        mem_exc = 1; mem_code = 5; mem_pc = 32'h0040_0020; mem_badvaddr = 32'h1000_0003;
        id_exc = 1; id_code = 8; id_pc = 32'h0040_001c;
        sb.push_back(wr(14, 32'h0040_0020));
        sb.push_back(wr(8, 32'h1000_0003));
        sb.push_back(wr(13, 32'h14));
        sb.push_back(wr(12, 32'h2));
        sb.push_back(rd(HANDLER));
        go("mem_adds", 5);

        // Interrupt masked by IE = 0
        @(negedge clk);
        status_in = 32'h0; int_ext = 1; mem_pc = 32'h0040_0030;
        repeat (3) @(posedge clk);
        #1;
        chk("int_masked_busy", 64'(busy), 64'd0);
        @(negedge clk);
        int_ext = 0;
        status_in = 32'h1; int_ext = 1;
        sb.push_back(wr(14, 32'h0040_0030));
        sb.push_back(wr(13, 32'h0));
        sb.push_back(wr(12, 32'h3));
        sb.push_back(rd(HANDLER));
        go("int_taken", 4);

        // Nested exception with EXL already set: no EPC write
        @(negedge clk);
        status_in = 32'h13; id_exc = 1; id_code = 10; id_pc = 32'h0040_0040;
        sb.push_back(wr(13, 32'h28));
        sb.push_back(wr(12, 32'h03));
        sb.push_back(rd(HANDLER));
        go("exl_ri", 3);

        // ERET
        @(negedge clk);
        status_in = 32'h3; epc_in = 32'h0040_0024; eret = 1;
        sb.push_back(wr(12, 32'h1));
        sb.push_back(rd(32'h0040_0024));
        go("eret", 2);

        // ERET together with a trap: exception path only
        @(negedge clk);
        status_in = 32'h1; eret = 1; ex_exc = 1; ex_code = 13; ex_pc = 32'h0040_0050;
        sb.push_back(wr(14, 32'h0040_0050));
        sb.push_back(wr(13, 32'h34));
        sb.push_back(wr(12, 32'h3));
        sb.push_back(rd(HANDLER));
        go("eret_vs_trap", 4);

        // IF fetch address error
        @(negedge clk);
        status_in = 32'h0; if_exc = 1; if_pc = 32'h0040_0063;
        sb.push_back(wr(14, 32'h0040_0063));
        sb.push_back(wr(8, 32'h0040_0063));
        sb.push_back(wr(13, 32'h10));
        sb.push_back(wr(12, 32'h2));
        sb.push_back(rd(HANDLER));
        go("if_adel", 5);

        // Asynchronous reset while in SAVE_CAUSE
        @(negedge clk);
        status_in = 32'h0; ex_exc = 1; ex_code = 12; ex_pc = 32'h0040_0070;
        sb.push_back(wr(14, 32'h0040_0070));
        @(posedge clk); #1;
        clear_reqs();
        @(posedge clk);
        #7;
        chk("pre_reset_epc_seen", 64'(sb.size()), 64'd0);
        reset = 0;
        #1;
        chk("async_reset_outputs", 64'({cop_we, cop_wreg, cop_wdata, flush, stall, busy, pc_redirect}), 64'd0);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        chk("post_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        ex_exc = 1; ex_code = 12; ex_pc = 32'h0040_0080;
        sb.push_back(wr(14, 32'h0040_0080));
        sb.push_back(wr(13, 32'h30));
        sb.push_back(wr(12, 32'h2));
        sb.push_back(rd(HANDLER));
        go("after_reset", 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
Cop0 exception-entry and ERET sequencer.
- Collects exception requests from the IF/ID/EX/MEM pipeline stages and the external interrupt line, and selects one by age priority.
- Drives the coprocessor write port over several cycles to save EPC, BADVADDR, CAUSE and STATUS, then redirects fetch to the kernel handler.
- Also sequences ERET: it clears EXL and returns the PC to EPC.
- Holds the pipeline flushed and stalled while it owns the coprocessor write port.

Parameters:
HANDLER_ADDR, 32'h8000_0180, kernel exception vector driven on pc_target at exception entry
REG_BADVADDR, 8, cop0 register index of BADVADDR
REG_STATUS, 12, cop0 register index of STATUS
REG_CAUSE, 13, cop0 register index of CAUSE
REG_EPC, 14, cop0 register index of EPC

Ports:
clk  in  1  clock, rising edge
reset  in  1  one clock; reset is asynchronous and active-low (0 = reset asserted)
mem_exc  in  1  MEM-stage exception request
mem_code  in  5  MEM exception code (4 = ADDRL, 5 = ADDRS, others legal)
mem_pc  in  32  PC of the faulting MEM instruction
mem_badvaddr  in  32  faulting data address
ex_exc / ex_code / ex_pc  in  1/5/32  EX-stage request (OVF = 12, TR = 13)
id_exc / id_code / id_pc  in  1/5/32  ID-stage request (SYS = 8, RI = 10)
if_exc  in  1  IF fetch address error (code 4 is implied)
if_pc  in  32  faulting fetch PC; also used as BADVADDR
int_ext  in  1  external interrupt level
eret  in  1  ERET committing (single-cycle pulse)
status_in  in  32  current cop0 STATUS (bit 0 IE, bit 1 EXL, bit 4 UM)
epc_in  in  32  current cop0 EPC
cop_we  out  1  coprocessor write enable
cop_wreg  out  5  coprocessor write register index
cop_wdata  out  32  coprocessor write data
flush  out  1  squash all pipeline stages
stall  out  1  hold the PC and pipeline registers
pc_redirect  out  1  load pc_target into the PC this cycle
pc_target  out  32  redirect address
busy  out  1  sequencer not in IDLE

Behaviour:
- States: IDLE, SAVE_EPC, SAVE_BADV, SAVE_CAUSE, SAVE_STATUS, ERET_STATUS, REDIRECT. All outputs are registered.
- Reset (asynchronous, asserted low): state goes to IDLE; all latched fields and all outputs are 0. This also applies mid-sequence; a partially written cop state is left as-is.
- Requests are sampled only in IDLE; any requests arriving in other states are ignored.
- Selection priority: mem > ex > id > if > int_ext.
- int_ext is eligible only when status_in[0] = 1 and status_in[1] = 0.
- When a request is taken, the sequencer latches:
  - code, PC and badvaddr (badvaddr only for MEM and IF sources);
  - the interrupt case, with code = 0 and pc = epc source mem_pc.
- A synchronous exception beats eret in the same cycle; eret is then dropped.
- IDLE to first state (next edge):
  - exception with status_in[1] = 0 → SAVE_EPC;
  - exception with status_in[1] = 1 → skip EPC and go directly to the BADV/CAUSE step;
  - eret only → ERET_STATUS.
- SAVE_EPC: cop_we = 1, wreg = REG_EPC, wdata = latched pc.
  - Next: SAVE_BADV if code is 4 or 5, else SAVE_CAUSE.
- SAVE_BADV: writes REG_BADVADDR with the latched badvaddr. Next: SAVE_CAUSE.
- SAVE_CAUSE: writes REG_CAUSE with code in bits 6:2 and all other bits 0. Next: SAVE_STATUS.
- SAVE_STATUS: writes REG_STATUS with status_in, EXL = 1, UM = 0. Next: REDIRECT with target HANDLER_ADDR.
- ERET_STATUS: writes REG_STATUS with status_in, EXL = 0. Next: REDIRECT with target epc_in sampled in this state.
- REDIRECT: pc_redirect = 1 and pc_target is valid for exactly one cycle; cop_we = 0. Next: IDLE.
- flush, stall and busy are 1 in every non-IDLE state and 0 in IDLE.
- cop_we is 1 only in the SAVE_* and ERET_STATUS states; cop_wreg and cop_wdata are 0 whenever cop_we = 0.
- Latency:
  - Non-address exception: detect at edge N; writes at N+1..N+3; redirect at N+4.
  - Address error: redirect at N+5.
  - ERET: redirect at N+2.
- A request held through REDIRECT is re-taken in IDLE. Upstream drops requests on flush.

Test Plan:
- ex_exc = 1, code 12, ex_pc = 0x0040_0010, status = 0 → EPC = 0x0040_0010, CAUSE = 0x30, STATUS = 0x2 on consecutive cycles; pc_target = 0x8000_0180 four cycles after detect.
- mem_exc code 5 with badvaddr 0x1000_0003, same cycle as id_exc code 8 → MEM wins; writes go to EPC, BADVADDR = 0x1000_0003, CAUSE = 0x14, STATUS; no SYS entry.
- int_ext = 1 with status = 0x0 → ignored. With status = 0x1 → CAUSE = 0x0 and STATUS = 0x3 written.
- status = 0x13 (EXL = 1), id_exc code 10 → no EPC write; CAUSE = 0x28; STATUS = 0x03; redirect 3 cycles after detect.
- eret with status = 0x3 and epc_in = 0x0040_0024 → STATUS = 0x1 written; pc_target = 0x0040_0024 two cycles later. eret together with ex_exc → exception path only.
- reset driven low during SAVE_CAUSE → outputs 0 immediately, without waiting for clk. After release, busy = 0 and a new request is sequenced normally.
